// File: rtl/lkt_pkg.sv
// lkt_pkg: definitions shared by the LKT write and lookup sides.
package lkt_pkg;
  localparam int LKT_ADDR_W_MAX = 7;
  localparam int LKT_DATA_W_MAX = 17;
  function automatic int lkt_addr_w(input int lookups, input int choices);
    return (lookups * choices > 1) ? $clog2(lookups * choices) : 1;
  endfunction
  typedef enum logic {LKT_WR_CLEAR, LKT_WR_RUN} lkt_wr_state_e;
  // Widest legal request; users narrow it to their own widths via the FIFO type parameter.
  typedef struct packed {
    logic [LKT_ADDR_W_MAX-1:0] addr;
    logic [LKT_DATA_W_MAX-1:0] data;
  } lkt_wr_req_t;
endpackage

// File: rtl/lkt_wr_fifo.sv
// lkt_wr_fifo: synchronous request FIFO exposing the head and the entry behind it.
module lkt_wr_fifo
  import lkt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = lkt_wr_req_t,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  T              din_i,
  output T              head_o,
  output T              nxt_o,
  output logic [CW-1:0] cnt_o,
  output logic          full_o,
  output logic          empty_o
);
  T mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk)
    if (push_i) mem[wr_q] <= din_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign head_o = mem[rd_q];
  assign nxt_o = mem[rd_q + 1'b1];
  assign cnt_o = cnt_q;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/lkt_table_writer.sv
// lkt_table_writer: LKT write agent; zero-fills the table after reset/init_start, then drains buffered requests.
// Define LKT_WR_PARITY_EN to append an even-parity bit to tbl_wr_data.
module lkt_table_writer
  import lkt_pkg::*;
#(
  parameter int RESULT_WIDTH = 3,
  parameter int NUM_LOOKUPS = 8,
  parameter int NUM_CHOICES = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int LK_W = NUM_LOOKUPS > 1 ? $clog2(NUM_LOOKUPS) : 1,
  localparam int CH_W = $clog2(NUM_CHOICES),
  localparam int ENTRIES = NUM_LOOKUPS * NUM_CHOICES,
  localparam int ADDR_W = lkt_addr_w(NUM_LOOKUPS, NUM_CHOICES),
`ifdef LKT_WR_PARITY_EN
  localparam int DW = RESULT_WIDTH + 1
`else
  localparam int DW = RESULT_WIDTH
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LK_W-1:0]         req_lookup,
  input  logic [CH_W-1:0]         req_choice,
  input  logic [RESULT_WIDTH-1:0] req_data,
  input  logic                    init_start,
  output logic                    tbl_wr_en,
  output logic [ADDR_W-1:0]       tbl_wr_addr,
  output logic [DW-1:0]           tbl_wr_data,
  input  logic                    tbl_wr_gnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err_range
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [(1<<LK_W)-1:0] LK_OK = {(1<<LK_W){1'b1}} >> ((1<<LK_W) - NUM_LOOKUPS);
  localparam logic [(1<<CH_W)-1:0] CH_OK = {(1<<CH_W){1'b1}} >> ((1<<CH_W) - NUM_CHOICES);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } req_t;
  lkt_wr_state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d, addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic pend_q, pend_d, en_q, en_d, done_q, done_d, err_q, err_d;
  logic full, empty, acc, ok, push, pop, fin, free, last, clr_go, avail;
  logic [CW-1:0] cnt;
  req_t inc, head, nxt, cand;
  assign ok = LK_OK[req_lookup] && CH_OK[req_choice];
  assign acc = req_valid && !full;
  assign push = acc && ok;
  assign inc.addr = ADDR_W'(int'(req_lookup) * NUM_CHOICES + int'(req_choice));
`ifdef LKT_WR_PARITY_EN
  assign inc.data = {^req_data, req_data};
`else
  assign inc.data = req_data;
`endif
  lkt_wr_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .din_i(inc),
    .head_o(head),
    .nxt_o(nxt),
    .cnt_o(cnt),
    .full_o(full),
    .empty_o(empty)
  );
  // The presented RUN write stays at the FIFO head until granted; the register preloads its successor.
  always_comb begin
    fin = en_q && tbl_wr_gnt;
    free = !en_q || tbl_wr_gnt;
    pop = state_q == LKT_WR_RUN && fin;
    last = state_q == LKT_WR_CLEAR && fin && clr_q == ADDR_W'(ENTRIES - 1);
    clr_go = state_q == LKT_WR_RUN && (init_start || pend_q);
    state_d = last ? LKT_WR_RUN : (clr_go && free) ? LKT_WR_CLEAR : state_q;
    pend_d = clr_go && !free;
    clr_d = state_q == LKT_WR_RUN ? '0 : fin ? clr_q + 1'b1 : clr_q;
    cand = pop ? (cnt == CW'(1) ? inc : nxt) : (empty ? inc : head);
    avail = push || (!empty && !(pop && cnt == CW'(1)));
    en_d = state_d == LKT_WR_CLEAR || avail;
    addr_d = state_d == LKT_WR_CLEAR ? clr_d : cand.addr;
    data_d = state_d == LKT_WR_CLEAR ? '0 : cand.data;
    done_d = last;
    err_d = acc && !ok;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LKT_WR_CLEAR;
      clr_q <= '0;
      pend_q <= 1'b0;
      en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      pend_q <= pend_d;
      en_q <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign req_ready = !full;
  assign tbl_wr_en = en_q;
  assign tbl_wr_addr = addr_q;
  assign tbl_wr_data = data_q;
  assign busy = state_q == LKT_WR_CLEAR;
  assign done = done_q;
  assign err_range = err_q;
endmodule
